icache_dm: RTL and testbench



---
 rtl/icache_dm.sv | 138 +++++++++++++
 tb/tb_icache_dm.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with 4-word lines.
// Hits return in one cycle. A miss refills the line word by word from a variable-latency memory.
module icache_dm #(
    parameter int unsigned LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        flush,
    output logic [31:0] cpu_rdata,
    output logic        cpu_valid,
    output logic        cpu_stall,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 28 - IW;

    typedef enum logic [1:0] {StIdle, StFill, StResp} state_e;

    state_e            state_q, state_d;
    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [LINES];
    logic [31:0]       data_q [LINES*4];
    logic [29:0]       addr_q;
    logic [1:0]        k_q;
    logic              issue_q;
    logic              flush_pend_q;
    logic              cpu_valid_q;
    logic [31:0]       cpu_rdata_q;

    logic [IW-1:0]     req_idx;
    logic [TW-1:0]     req_tag;
    logic [1:0]        req_word;
    logic [IW-1:0]     miss_idx;
    logic [TW-1:0]     miss_tag;
    logic [1:0]        miss_word;
    logic              hit;
    logic              take_done;
    logic [1:0]        k_sel;
    logic              unused_byte_bits;

    assign req_idx   = cpu_addr[4 +: IW];
    assign req_tag   = cpu_addr[31 -: TW];
    assign req_word  = cpu_addr[3:2];
    assign miss_idx  = addr_q[2 +: IW];
    assign miss_tag  = addr_q[29 -: TW];
    assign miss_word = addr_q[1:0];
    assign unused_byte_bits = ^cpu_addr[1:0];

    assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // The cycle that issues word 0 cannot also carry its completion.
    assign take_done = (state_q == StFill) && !issue_q && mem_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (cpu_req && (flush || !hit)) state_d = StFill;
            StFill: if (take_done && (k_q == 2'd3)) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next word's read is issued in the same cycle the previous one completes.
    always_comb begin
        k_sel    = take_done ? k_q + 2'd1 : k_q;
        mem_en   = issue_q || (take_done && (k_q != 2'd3));
        mem_addr = (state_q == StFill) ? {addr_q[29:2], k_sel, 2'b00} : 32'h0;
    end

    assign cpu_valid = cpu_valid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_stall = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            addr_q       <= '0;
            k_q          <= '0;
            issue_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            cpu_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_q     <= 1'b0;
            cpu_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (flush) valid_q <= '0;
                    if (cpu_req) begin
                        if (hit && !flush) begin
                            cpu_valid_q <= 1'b1;
                            cpu_rdata_q <= data_q[{req_idx, req_word}];
                        end else begin
                            addr_q  <= cpu_addr[31:2];
                            k_q     <= '0;
                            issue_q <= 1'b1;
                        end
                    end
                end
                StFill: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (take_done) begin
                        k_q <= k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            valid_q[miss_idx] <= 1'b1;
                            cpu_valid_q       <= 1'b1;
                            cpu_rdata_q       <= (miss_word == 2'd3) ? mem_rdata
                                                 : data_q[{miss_idx, miss_word}];
                        end
                    end
                end
                StResp: begin
                    // A flush seen during the miss leaves the fresh line invalid too.
                    if (flush || flush_pend_q) valid_q <= '0;
                    flush_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && take_done) begin
            data_q[{miss_idx, k_q}] <= mem_rdata;
            if (k_q == 2'd3) tag_q[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: latency-programmable memory responder plus a line-level cache model
// tracking which lines hold which tags.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        flush;
    logic [31:0] cpu_rdata;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_done;

    icache_dm #(.LINES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .flush     (flush),
        .cpu_rdata (cpu_rdata),
        .cpu_valid (cpu_valid),
        .cpu_stall (cpu_stall),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Cache model: 16 lines, tag = addr[31:8], index = addr[7:4].
    bit          mv [16];
    logic [23:0] mt [16];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0600) return 32'hA000_0001;
        if (w == 32'h0000_0608) return 32'hA000_0003;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: mem_done arrives lat_cfg cycles after each mem_en.
    int          lat_cfg = 1;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] resp_addr = '0;
    logic        resp_done = 1'b0;
    logic        inj_done = 1'b0;

    assign mem_done  = resp_done | inj_done;
    assign mem_rdata = resp_done ? mem_val(resp_addr) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (mem_en) begin
            pend_addr = mem_addr;
            cnt = lat_cfg;
        end
    end

    always @(posedge clk) begin
        #1;
        resp_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                resp_done = 1'b1;
                resp_addr = pend_addr;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 0;
    endtask

    // One request; fc = -1 no flush, 0 flush with the request, >0 flush in that later cycle.
    task automatic access(input logic [31:0] addr, input int fc, input string name);
        int          idx;
        bit          exp_hit;
        int          exp_c;
        int          got;
        int          nen;
        logic [31:0] q [$];
        logic [31:0] rd;
        bit          st;
        idx = int'(addr[7:4]);
        if (fc == 0) model_clear();
        exp_hit = mv[idx] && (mt[idx] == addr[31:8]);
        exp_c = exp_hit ? 1 : 2 + 4 * lat_cfg;
        got = -1;
        nen = 0;
        rd = '0;
        st = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_addr = addr;
        flush = (fc == 0);
        @(negedge clk);
        n_cmp++;
        if (cpu_stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s stall_at_req: got %b want 0", name, cpu_stall);
        end
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            cpu_req = (c < exp_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            cpu_addr = $urandom;
            flush = (c == fc);
            @(negedge clk);
            if (mem_en) begin
                nen++;
                q.push_back(mem_addr);
            end
            if (cpu_valid) begin
                got = c;
                rd = cpu_rdata;
                st = cpu_stall;
                break;
            end
        end
        n_cmp++;
        if (got != exp_c) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, got, exp_c);
        end
        n_cmp++;
        if (rd !== mem_val(addr)) begin
            n_err++;
            $display("FAIL %s rdata: got %h want %h", name, rd, mem_val(addr));
        end
        n_cmp++;
        if (st !== !exp_hit) begin
            n_err++;
            $display("FAIL %s stall_at_valid: got %b want %b", name, st, !exp_hit);
        end
        n_cmp++;
        if (nen != (exp_hit ? 0 : 4)) begin
            n_err++;
            $display("FAIL %s mem_en_count: got %0d want %0d", name, nen, exp_hit ? 0 : 4);
        end else if (!exp_hit) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (q[k] !== ({addr[31:4], 4'h0} + 32'(4 * k))) begin
                    n_err++;
                    $display("FAIL %s mem_addr%0d: got %h want %h", name, k, q[k],
                             {addr[31:4], 4'h0} + 32'(4 * k));
                end
            end
        end
        if (!exp_hit) begin
            mv[idx] = 1;
            mt[idx] = addr[31:8];
        end
        if (fc > 0) model_clear();
        if (flush) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp += 5;
        if (cpu_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", cpu_valid); end
        if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
        if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        model_clear();
    endtask

    task automatic test_cold_miss();
        lat_cfg = 1;
        access(32'h0000_0600, -1, "cold_miss");
        access(32'h0000_0608, -1, "hit_0608");
    endtask

    task automatic test_conflict();
        access(32'h0000_0700, -1, "conflict_0700");
        access(32'h0000_0600, -1, "evicted_0600");
    endtask

    task automatic test_var_latency();
        lat_cfg = 3;
        access(32'h0000_0A40, -1, "lat3_miss");
        lat_cfg = 1;
        @(posedge clk); #1;
        inj_done = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cpu_valid, cpu_stall, mem_en} !== 3'b000) begin
            n_err++;
            $display("FAIL spurious_done: got %b want 000", {cpu_valid, cpu_stall, mem_en});
        end
        @(posedge clk); #1;
        inj_done = 1'b0;
        access(32'h0000_0A44, -1, "hit_after_spurious");
    endtask

    task automatic test_flush();
        access(32'h0000_0700, -1, "flush_evict");
        access(32'h0000_0600, 3, "flush_mid_fill");
        access(32'h0000_0600, -1, "after_flush");
        access(32'h0000_0600, 0, "flush_with_req");
    endtask

    task automatic test_reset_mid_miss();
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_addr = 32'h0000_0800;
        flush = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            rst = (c == 3);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (mem_en !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_en: got %b want 0", mem_en); end
        if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b want 0", cpu_stall); end
        if (cpu_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", cpu_valid); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_valid || mem_en) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL rstmid_quiet: got activity 1 want 0");
        end
        model_clear();
        access(32'h0000_0600, -1, "miss_after_rstmid");
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        access(32'h0000_0600, -1, "b2b_prime");
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            cpu_req = (i < 4);
            cpu_addr = 32'h0000_0600 + 32'(4 * i);
            @(negedge clk);
            if (i > 0) begin
                want = mem_val(32'h0000_0600 + 32'(4 * (i - 1)));
                n_cmp++;
                if (!cpu_valid || cpu_rdata !== want || mem_en) begin
                    n_err++;
                    $display("FAIL b2b_%0d: got v=%b d=%h en=%b want v=1 d=%h en=0",
                             i, cpu_valid, cpu_rdata, mem_en, want);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          fc;
        for (int n = 0; n < 40; n++) begin
            a = {16'h0, 6'($urandom_range(0, 2)), 2'b00, 4'($urandom_range(0, 3)), 4'($urandom)};
            lat_cfg = $urandom_range(1, 3);
            fc = -1;
            if ($urandom_range(0, 9) == 0) begin
                fc = 0;
            end else if ($urandom_range(0, 9) == 0 && !(mv[a[7:4]] && mt[a[7:4]] == a[31:8])) begin
                fc = $urandom_range(1, 2 + 4 * lat_cfg);
            end
            access(a, fc, "random");
        end
        lat_cfg = 1;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = '0;
        flush = 1'b0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_var_latency();
        test_flush();
        test_reset_mid_miss();
        test_back_to_back();
        test_random();
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
